// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// seg_scan_ctrl: memory-mapped multiplexed seven-segment scanner.
// Live registers are written from the bus; shadow copies are taken at each
// frame boundary so a frame never shows a half-updated value. One lane per
// segment bank picks the digit for the current slot and drives its
// segment bus.

// seg_scan_lane: one segment bank. It selects the digit for the current
// slot, decodes it or passes its raw pattern through, and registers the
// enables and segments.
module seg_scan_lane #(
  parameter int BANK_DIGITS = 4,
  parameter int SLOT_W      = 2
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SLOT_W-1:0]            slot,
  input  logic                         act,       // en and past the dead time
  input  logic                         hex_mode,
  input  logic [BANK_DIGITS-1:0][3:0]  nib,
  input  logic [BANK_DIGITS-1:0][6:0]  raw_seg,
  input  logic [BANK_DIGITS-1:0]       dp,
  input  logic [BANK_DIGITS-1:0]       off,       // forced blank or LZ-blanked
  output logic [BANK_DIGITS-1:0]       dig_en,
  output logic [7:0]                   seg
);
  logic [3:0]             sel_nib;
  logic [6:0]             sel_raw;
  logic                   sel_dp, sel_off, on;
  logic [BANK_DIGITS-1:0] sel_oh;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // pick the digit this bank is scanning in the current slot
  always_comb begin
    sel_nib = '0;
    sel_raw = '0;
    sel_dp  = 1'b0;
    sel_off = 1'b1;
    sel_oh  = '0;
    for (int k = 0; k < BANK_DIGITS; k++) begin
      if (slot == SLOT_W'(k)) begin
        sel_nib   = nib[k];
        sel_raw   = raw_seg[k];
        sel_dp    = dp[k];
        sel_off   = off[k];
        sel_oh[k] = 1'b1;
      end
    end
  end

  assign on = act & ~sel_off;

  // register enables and segments; segments go dark with the enable
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en <= '0;
      seg    <= '0;
    end else begin
      dig_en <= on ? sel_oh : '0;
      seg    <= on ? {sel_dp, (hex_mode ? hex7(sel_nib) : sel_raw)} : 8'h00;
    end
  end
endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int BANK_DIGITS = 4,
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD_CYCLES = 2
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [3:0]                  addr,
  input  logic [31:0]                 wdata,
  output logic [31:0]                 rdata,
  output logic [NUM_DIGITS-1:0]       digits,
  output logic [NUM_DIGITS/BANK_DIGITS*8-1:0] segs,
  output logic                        frame_tick
);
  localparam int NUM_BANKS = NUM_DIGITS / BANK_DIGITS;
  localparam int CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLOT_W    = (BANK_DIGITS > 1) ? $clog2(BANK_DIGITS) : 1;

  // scan position
  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] slot;
  logic              cnt_last, slot_last, frame_end, in_win, act;

  // live registers
  logic [31:0]                   data_q;
  logic                          en_q, raw_q, lzb_q;
  logic [NUM_DIGITS-1:0]         dp_q, blank_q;
  logic [NUM_DIGITS-1:0][6:0]    rseg_q;

  // shadow registers (everything but en)
  logic [31:0]                   data_sh;
  logic                          raw_sh, lzb_sh;
  logic [NUM_DIGITS-1:0]         dp_sh, blank_sh;
  logic [NUM_DIGITS-1:0][6:0]    rseg_sh;

  logic [NUM_DIGITS-1:0][3:0]    nib_sh;
  logic [NUM_DIGITS-1:0]         lz, off;
  logic                          zero_run;
  logic [31:0]                   rd_nx;

  assign cnt_last  = (cnt == CNT_W'(SCAN_DIV - 1));
  assign slot_last = (slot == SLOT_W'(BANK_DIGITS - 1));
  assign frame_end = cnt_last & slot_last;

  generate
    if (DEAD_CYCLES == 0) begin : g_nodead
      assign in_win = 1'b1;
    end else begin : g_dead
      assign in_win = (cnt >= CNT_W'(DEAD_CYCLES));
    end
  endgenerate

  assign act = en_q & in_win;

  // slot timer and slot counter; frame_tick marks the wrap back to slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      slot       <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (cnt_last) begin
        cnt  <= '0;
        slot <= slot_last ? '0 : slot + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // bus writes into the live registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      en_q    <= 1'b0;
      raw_q   <= 1'b0;
      lzb_q   <= 1'b0;
      dp_q    <= '0;
      blank_q <= '0;
      rseg_q  <= '0;
    end else if (wr_en) begin
      case (addr)
        4'd0: data_q <= wdata;
        4'd1: begin
          en_q  <= wdata[0];
          raw_q <= wdata[1];
          lzb_q <= wdata[2];
          dp_q  <= wdata[8 +: NUM_DIGITS];
        end
        4'd2: blank_q <= wdata[NUM_DIGITS-1:0];
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (addr == 4'(8 + i)) rseg_q[i] <= wdata[6:0];
        end
      endcase
    end
  end

  // shadows sample the live registers on the frame boundary edge, so a
  // write on that same edge lands in the following frame
  always_ff @(posedge clk) begin
    if (rst) begin
      data_sh  <= '0;
      raw_sh   <= 1'b0;
      lzb_sh   <= 1'b0;
      dp_sh    <= '0;
      blank_sh <= '0;
      rseg_sh  <= '0;
    end else if (frame_end) begin
      data_sh  <= data_q;
      raw_sh   <= raw_q;
      lzb_sh   <= lzb_q;
      dp_sh    <= dp_q;
      blank_sh <= blank_q;
      rseg_sh  <= rseg_q;
    end
  end

  // read mux for the registered readback; unmapped addresses read 0
  always_comb begin
    rd_nx = '0;
    case (addr)
      4'd0: rd_nx = data_q;
      4'd1: begin
        rd_nx[2:0]            = {lzb_q, raw_q, en_q};
        rd_nx[8 +: NUM_DIGITS] = dp_q;
      end
      4'd2: rd_nx[NUM_DIGITS-1:0] = blank_q;
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (addr == 4'(8 + i)) rd_nx[6:0] = rseg_q[i];
      end
    endcase
  end

  // registered read data
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= rd_nx;
  end

  assign nib_sh = data_sh[NUM_DIGITS*4-1:0];

  // leading-zero mask: walk down from the top digit while nibbles stay 0;
  // digit 0 is never included
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (nib_sh[i] == 4'h0);
      lz[i]    = zero_run & lzb_sh & ~raw_sh;
    end
  end

  assign off = blank_sh | lz;

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      seg_scan_lane #(
        .BANK_DIGITS (BANK_DIGITS),
        .SLOT_W      (SLOT_W)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .slot     (slot),
        .act      (act),
        .hex_mode (~raw_sh),
        .nib      (nib_sh[b*BANK_DIGITS +: BANK_DIGITS]),
        .raw_seg  (rseg_sh[b*BANK_DIGITS +: BANK_DIGITS]),
        .dp       (dp_sh[b*BANK_DIGITS +: BANK_DIGITS]),
        .off      (off[b*BANK_DIGITS +: BANK_DIGITS]),
        .dig_en   (digits[b*BANK_DIGITS +: BANK_DIGITS]),
        .seg      (segs[8*b +: 8])
      );
    end
  endgenerate
endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// tb_seg_scan_ctrl: directed vectors against hand-computed values, with
// SCAN_DIV=4, DEAD_CYCLES=1, 8 digits in two banks of 4 (16-cycle frame).
module tb_seg_scan_ctrl;
  logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [7:0]  digits;
  logic [15:0] segs;
  logic        frame_tick;

  int n_chk = 0, n_pass = 0;

  seg_scan_ctrl #(.NUM_DIGITS(8), .BANK_DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .digits(digits), .segs(segs), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [3:0] a; logic [31:0] d; logic [31:0] exp; } reg_vec_t;
  typedef struct { int j; logic [7:0] dig; logic [15:0] seg; } scan_vec_t;

  reg_vec_t  reg_tbl[8];
  scan_vec_t vecs[$];
  int        on_cnt[8];
  logic [7:0] ever_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  // step until frame_tick is seen (strictly after the current edge)
  task automatic wait_ft();
    int n = 0;
    do begin tick(); n++; end while (!frame_tick && n < 40);
    chk("wait_frame_tick", {31'd0, frame_tick}, 32'd1);
  endtask

  // one frame right after a frame edge; j counts edges after that edge
  task automatic run_frame(input string tag);
    for (int i = 0; i < 8; i++) on_cnt[i] = 0;
    ever_on = '0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      for (int i = 0; i < 8; i++) if (digits[i]) on_cnt[i]++;
      ever_on |= digits;
      foreach (vecs[v]) if (vecs[v].j == j) begin
        chk($sformatf("%s_j%0d_digits", tag, j), {24'd0, digits}, {24'd0, vecs[v].dig});
        chk($sformatf("%s_j%0d_segs", tag, j), {16'd0, segs}, {16'd0, vecs[v].seg});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ft_q[$];
    int dark_bad, early;

    reg_tbl[0] = '{1'b1, 4'd0,  32'h7654_3210, 32'h7654_3210};
    reg_tbl[1] = '{1'b1, 4'd1,  32'hDEAD_BEEF, 32'h0000_BE07};
    reg_tbl[2] = '{1'b1, 4'd2,  32'h0000_0123, 32'h0000_0023};
    reg_tbl[3] = '{1'b1, 4'd8,  32'h0000_00FF, 32'h0000_007F};
    reg_tbl[4] = '{1'b1, 4'd15, 32'h0000_002A, 32'h0000_002A};
    reg_tbl[5] = '{1'b1, 4'd5,  32'h0000_FFFF, 32'h0000_0000};
    reg_tbl[6] = '{1'b0, 4'd3,  32'h0000_0000, 32'h0000_0000};
    reg_tbl[7] = '{1'b0, 4'd0,  32'h0000_0000, 32'h7654_3210};

    // reset state
    repeat (3) tick();
    chk("rst_digits", {24'd0, digits}, 32'd0);
    chk("rst_segs", {16'd0, segs}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ft", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;

    // idle: dark, frame_tick at 16 and 32
    dark_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (digits !== 8'd0 || segs !== 16'd0) dark_bad++;
      if (frame_tick) ft_q.push_back(k);
    end
    chk("idle_dark", dark_bad, 0);
    chk("idle_ft_count", ft_q.size(), 2);
    chk("idle_ft_first", (ft_q.size() > 0) ? ft_q[0] : -1, 16);
    chk("idle_ft_second", (ft_q.size() > 1) ? ft_q[1] : -1, 32);

    // register write/readback table
    foreach (reg_tbl[t]) begin
      addr = reg_tbl[t].a; wdata = reg_tbl[t].d; wr_en = reg_tbl[t].wr;
      tick();
      wr_en = 1'b0;
      tick();
      chk($sformatf("reg%0d_a%0d", t, reg_tbl[t].a), rdata, reg_tbl[t].exp);
    end
    wr(4'd1, 32'd0); wr(4'd2, 32'd0); wr(4'd8, 32'd0); wr(4'd15, 32'd0);

    // hex scan
    wr(4'd0, 32'h7654_3210); wr(4'd1, 32'd1);
    wait_ft();
    vecs.delete();
    vecs.push_back('{1,  8'h00, 16'h0000});
    vecs.push_back('{2,  8'h11, 16'h663F});
    vecs.push_back('{4,  8'h11, 16'h663F});
    vecs.push_back('{5,  8'h00, 16'h0000});
    vecs.push_back('{6,  8'h22, 16'h6D06});
    vecs.push_back('{10, 8'h44, 16'h7D5B});
    vecs.push_back('{13, 8'h00, 16'h0000});
    vecs.push_back('{14, 8'h88, 16'h074F});
    vecs.push_back('{16, 8'h88, 16'h074F});
    run_frame("hex");
    for (int i = 0; i < 8; i++) chk($sformatf("hex_on_cnt%0d", i), on_cnt[i], 3);

    // leading-zero blanking
    wr(4'd0, 32'h0000_0050); wr(4'd1, 32'h5);
    wait_ft();
    vecs.delete();
    vecs.push_back('{2,  8'h01, 16'h003F});
    vecs.push_back('{6,  8'h02, 16'h006D});
    vecs.push_back('{10, 8'h00, 16'h0000});
    vecs.push_back('{14, 8'h00, 16'h0000});
    run_frame("lzb");
    chk("lzb_ever_on", {24'd0, ever_on}, 32'h03);

    // raw mode, dp, forced blank
    wr(4'd1, 32'h0303); wr(4'd8, 32'h49); wr(4'd2, 32'h04);
    wait_ft();
    vecs.delete();
    vecs.push_back('{2,  8'h11, 16'h00C9});
    vecs.push_back('{6,  8'h22, 16'h0080});
    vecs.push_back('{10, 8'h40, 16'h0000});
    vecs.push_back('{14, 8'h88, 16'h0000});
    run_frame("raw");
    chk("raw_ever_on", {24'd0, ever_on}, 32'hFB);

    // write landing on the frame boundary edge
    wr(4'd1, 32'd1); wr(4'd2, 32'd0); wr(4'd0, 32'h1111_1111);
    wait_ft();
    repeat (15) tick();
    wr(4'd0, 32'h2222_2222);
    chk("edge_wr_ft", {31'd0, frame_tick}, 32'd1);
    vecs.delete();
    vecs.push_back('{2,  8'h11, 16'h0606});
    vecs.push_back('{8,  8'h22, 16'h0606});
    vecs.push_back('{16, 8'h88, 16'h0606});
    run_frame("edge_old");
    vecs.delete();
    vecs.push_back('{2,  8'h11, 16'h5B5B});
    vecs.push_back('{8,  8'h22, 16'h5B5B});
    vecs.push_back('{16, 8'h88, 16'h5B5B});
    run_frame("edge_new");

    // reset in the middle of slot 2
    repeat (10) tick();
    chk("pre_rst_digits", {24'd0, digits}, 32'h44);
    rst = 1'b1;
    tick();
    chk("mid_rst_digits", {24'd0, digits}, 32'd0);
    chk("mid_rst_segs", {16'd0, segs}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_ft", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    wr(4'd1, 32'd1);                     // edge 1 after release
    tick();                              // edge 2
    chk("post_rst_digits_s0", {24'd0, digits}, 32'h11);
    chk("post_rst_segs_s0", {16'd0, segs}, 32'h3F3F);
    chk("post_rst_rdata_ctrl", rdata, 32'd1);
    repeat (4) tick();                   // edge 6
    chk("post_rst_digits_s1", {24'd0, digits}, 32'h22);
    early = 0;
    for (int k = 7; k <= 16; k++) begin
      tick();
      if (k < 16 && frame_tick) early++;
      if (k == 16) chk("post_rst_ft16", {31'd0, frame_tick}, 32'd1);
    end
    chk("post_rst_ft_early", early, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
